wb_arbiter_2m: RTL and testbench

Two-master Wishbone arbiter that shares one Wishbone slave, typically the `wb_bram` block RAM, between two requesters such as a CPU port and a DMA/video port. It grants the bus per cycle-frame (CYC high), round-robin between masters. It holds the grant for the whole frame, including CTI-tagged bursts. A watchdog terminates stalled frames with ERR.

---
 rtl/wb_arbiter_2m.sv | 172 +++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin per CYC frame, grant held for the whole frame,
// with a watchdog that terminates stalled strobes by returning ERR to the owner.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_ms,
  output logic [31:0] m0_dat_sm,
  input  logic [3:0]  m0_sel,
  input  logic        m0_we,
  input  logic        m0_stb,
  input  logic        m0_cyc,
  input  logic [2:0]  m0_cti,
  input  logic [1:0]  m0_bte,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_rty,
  // master 1
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_ms,
  output logic [31:0] m1_dat_sm,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_stb,
  input  logic        m1_cyc,
  input  logic [2:0]  m1_cti,
  input  logic [1:0]  m1_bte,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_rty,
  // shared slave
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_ms,
  input  logic [31:0] s_dat_sm,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_stb,
  output logic        s_cyc,
  output logic [2:0]  s_cti,
  output logic [1:0]  s_bte,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_rty,
  // status
  output logic [1:0]  grant,
  output logic        tmo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        owner_req;
  logic        fire;

  // last starts at 1 so that master 0 wins the first tie after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc) begin
          state_d = OWN0;
        end else if (m1_cyc) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc) begin
          state_d = m1_cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc) begin
          state_d = m0_cyc ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == OWN0 && state_q != OWN0) begin
      last_d = 1'b0;
    end else if (state_d == OWN1 && state_q != OWN1) begin
      last_d = 1'b1;
    end
  end

  // Watchdog never looks at s_ack when deciding to fire, so the forced-low
  // strobe cannot form a loop through a combinational slave ack.
  always_comb begin
    owner_req = ((state_q == OWN0) && m0_cyc && m0_stb) ||
                ((state_q == OWN1) && m1_cyc && m1_stb);
    fire      = owner_req && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    if ((state_d != state_q) || s_ack || s_err || s_rty || fire) begin
      cnt_d = 8'd0;
    end else if (owner_req) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    grant     = 2'b00;
    tmo       = fire;
    s_adr     = m0_adr;
    s_dat_ms  = m0_dat_ms;
    s_sel     = m0_sel;
    s_we      = m0_we;
    s_cti     = m0_cti;
    s_bte     = m0_bte;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    m0_dat_sm = s_dat_sm;
    m1_dat_sm = s_dat_sm;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_rty    = 1'b0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_rty    = 1'b0;
    unique case (state_q)
      OWN0: begin
        grant  = 2'b01;
        s_cyc  = m0_cyc;
        s_stb  = m0_stb && !fire;
        m0_ack = s_ack;
        m0_err = s_err || fire;
        m0_rty = s_rty;
      end
      OWN1: begin
        grant    = 2'b10;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_we     = m1_we;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        s_cyc    = m1_cyc;
        s_stb    = m1_stb && !fire;
        m1_ack   = s_ack;
        m1_err   = s_err || fire;
        m1_rty   = s_rty;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m with a small block-RAM style slave stub
// (combinational write ack, registered read ack) that can be told to stall.
module tb_wb_arbiter_2m;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
   logic [3:0]  m0_sel;
   logic        m0_we, m0_stb, m0_cyc;
   logic [2:0]  m0_cti;
   logic [1:0]  m0_bte;
   logic        m0_ack, m0_err, m0_rty;

   logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
   logic [3:0]  m1_sel;
   logic        m1_we, m1_stb, m1_cyc;
   logic [2:0]  m1_cti;
   logic [1:0]  m1_bte;
   logic        m1_ack, m1_err, m1_rty;

   logic [31:0] s_adr, s_dat_ms, s_dat_sm;
   logic [3:0]  s_sel;
   logic        s_we, s_stb, s_cyc;
   logic [2:0]  s_cti;
   logic [1:0]  s_bte;
   logic        s_ack, s_err, s_rty;

   logic [1:0]  grant;
   logic        tmo;

   logic        slaveStall;
   logic        tbErr;
   logic        tbRty;
   logic        rdAck;
   logic [31:0] mem [16];

   int          checkCount = 0;
   int          errCount   = 0;

   always #5 clk = ~clk;

   wb_arbiter_2m #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_adr    (m0_adr),
      .m0_dat_ms (m0_dat_ms),
      .m0_dat_sm (m0_dat_sm),
      .m0_sel    (m0_sel),
      .m0_we     (m0_we),
      .m0_stb    (m0_stb),
      .m0_cyc    (m0_cyc),
      .m0_cti    (m0_cti),
      .m0_bte    (m0_bte),
      .m0_ack    (m0_ack),
      .m0_err    (m0_err),
      .m0_rty    (m0_rty),
      .m1_adr    (m1_adr),
      .m1_dat_ms (m1_dat_ms),
      .m1_dat_sm (m1_dat_sm),
      .m1_sel    (m1_sel),
      .m1_we     (m1_we),
      .m1_stb    (m1_stb),
      .m1_cyc    (m1_cyc),
      .m1_cti    (m1_cti),
      .m1_bte    (m1_bte),
      .m1_ack    (m1_ack),
      .m1_err    (m1_err),
      .m1_rty    (m1_rty),
      .s_adr     (s_adr),
      .s_dat_ms  (s_dat_ms),
      .s_dat_sm  (s_dat_sm),
      .s_sel     (s_sel),
      .s_we      (s_we),
      .s_stb     (s_stb),
      .s_cyc     (s_cyc),
      .s_cti     (s_cti),
      .s_bte     (s_bte),
      .s_ack     (s_ack),
      .s_err     (s_err),
      .s_rty     (s_rty),
      .grant     (grant),
      .tmo       (tmo)
   );

   // Slave stub: writes ack in the strobe cycle, reads ack one cycle later.
   always @(posedge clk) begin
      if (s_cyc && s_stb && s_we && !slaveStall) begin
         for (int b = 0; b < 4; b++) begin
            if (s_sel[b]) mem[s_adr[5:2]][8*b +: 8] <= s_dat_ms[8*b +: 8];
         end
      end
   end

   // Registered read data and a single-cycle read ack pulse per strobe.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdAck    <= 1'b0;
         s_dat_sm <= 32'd0;
      end else begin
         rdAck    <= s_cyc && s_stb && !s_we && !rdAck && !slaveStall;
         s_dat_sm <= mem[s_adr[5:2]];
      end
   end

   assign s_ack = !slaveStall && s_cyc && s_stb && (s_we || rdAck);
   assign s_err = tbErr;
   assign s_rty = tbRty;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one master's request signals.
   task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                input logic [2:0] cti, input logic [31:0] adr, input logic [31:0] dat);
      if (m == 0) begin
         m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_cti = cti; m0_adr = adr; m0_dat_ms = dat;
      end else begin
         m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_cti = cti; m1_adr = adr; m1_dat_ms = dat;
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic pulseReset();
      stepCycle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      slaveStall = 1'b0;
      tbErr      = 1'b0;
      tbRty      = 1'b0;
      m0_sel = 4'hF; m1_sel = 4'hF; m0_bte = 2'b00; m1_bte = 2'b00;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;

      // Reset values
      #3;
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_tmo", 32'(tmo), 32'd0);
      checkOutput("rst_s_cyc", 32'(s_cyc), 32'd0);
      checkOutput("rst_s_stb", 32'(s_stb), 32'd0);
      checkOutput("rst_m0_ack", 32'(m0_ack), 32'd0);
      checkOutput("rst_m1_ack", 32'(m1_ack), 32'd0);
      #9 rst_n = 1'b1;

      // Single master write then read
      stepCycle();
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h10, 32'hDEADBEEF);
      settle();
      checkOutput("wr_idle_grant", 32'(grant), 32'd0);
      checkOutput("wr_idle_s_cyc", 32'(s_cyc), 32'd0);
      stepCycle(); settle();
      checkOutput("wr_grant", 32'(grant), 32'd1);
      checkOutput("wr_s_cyc", 32'(s_cyc), 32'd1);
      checkOutput("wr_s_stb", 32'(s_stb), 32'd1);
      checkOutput("wr_s_dat", s_dat_ms, 32'hDEADBEEF);
      checkOutput("wr_s_bte", 32'(s_bte), 32'd0);
      checkOutput("wr_m0_ack", 32'(m0_ack), 32'd1);
      checkOutput("wr_m1_ack", 32'(m1_ack), 32'd0);
      stepCycle();
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
      settle();
      checkOutput("rd_m0_ack_early", 32'(m0_ack), 32'd0);
      stepCycle(); settle();
      checkOutput("rd_m0_ack", 32'(m0_ack), 32'd1);
      checkOutput("rd_m0_data", m0_dat_sm, 32'hDEADBEEF);
      checkOutput("rd_m1_data_bcast", m1_dat_sm, 32'hDEADBEEF);
      checkOutput("rd_m1_ack", 32'(m1_ack), 32'd0);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
      stepCycle(); settle();
      checkOutput("wr_release_grant", 32'(grant), 32'd0);

      // Tie and round-robin out of reset
      pulseReset();
      stepCycle();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h4, 32'h0);
      settle();
      checkOutput("tie_idle_grant", 32'(grant), 32'd0);
      stepCycle(); settle();
      checkOutput("tie_first_grant", 32'(grant), 32'd1);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      stepCycle(); settle();
      checkOutput("tie_handover_grant", 32'(grant), 32'd2);
      checkOutput("tie_handover_s_adr", s_adr, 32'h4);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h4, 32'h0);
      stepCycle(); settle();
      checkOutput("tie_idle2_grant", 32'(grant), 32'd0);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h4, 32'h0);
      stepCycle(); settle();
      checkOutput("tie_second_grant", 32'(grant), 32'd1);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h4, 32'h0);
      stepCycle(); settle();
      checkOutput("tie_end_grant", 32'(grant), 32'd0);

      // Burst hold: m0 4-beat incrementing read, m1 requesting from beat 1
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      stepCycle(); settle();
      checkOutput("burst_start_grant", 32'(grant), 32'd1);
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h40, 32'h0);
      for (int b = 0; b < 4; b++) begin
         logic [2:0] cti;
         cti = (b == 3) ? 3'b111 : 3'b010;
         applyStimulus(0, 1'b1, 1'b1, 1'b0, cti, 32'h10 + 32'(4 * b), 32'h0);
         settle();
         checkOutput($sformatf("burst%0d_wait_grant", b), 32'(grant), 32'd1);
         checkOutput($sformatf("burst%0d_s_cti", b), 32'(s_cti), 32'(cti));
         stepCycle(); settle();
         checkOutput($sformatf("burst%0d_ack_grant", b), 32'(grant), 32'd1);
         checkOutput($sformatf("burst%0d_m0_ack", b), 32'(m0_ack), 32'd1);
         checkOutput($sformatf("burst%0d_m1_ack", b), 32'(m1_ack), 32'd0);
         if (b == 3) applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         stepCycle();
      end
      settle();
      checkOutput("burst_handover_grant", 32'(grant), 32'd2);
      checkOutput("burst_handover_s_adr", s_adr, 32'h40);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      stepCycle(); settle();
      checkOutput("burst_end_grant", 32'(grant), 32'd0);

      // Ack isolation with slave RTY/ERR passthrough to the owner only
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h20, 32'h0);
      stepCycle(); settle();
      checkOutput("iso_grant", 32'(grant), 32'd1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1'b1, 1'b1, 1'b1, 3'b000, 32'h20 + 32'(4 * i), 32'(i));
         applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'b000, 32'hABC0, 32'h0);
         tbRty = (i == 4);
         tbErr = (i == 6);
         settle();
         checkOutput($sformatf("iso%0d_m1_ack", i), 32'(m1_ack), 32'd0);
         checkOutput($sformatf("iso%0d_m1_err", i), 32'(m1_err), 32'd0);
         checkOutput($sformatf("iso%0d_m1_rty", i), 32'(m1_rty), 32'd0);
         checkOutput($sformatf("iso%0d_s_adr", i), s_adr, 32'h20 + 32'(4 * i));
         checkOutput($sformatf("iso%0d_m0_rty", i), 32'(m0_rty), 32'(i == 4));
         checkOutput($sformatf("iso%0d_m0_err", i), 32'(m0_err), 32'(i == 6));
         checkOutput($sformatf("iso%0d_grant", i), 32'(grant), 32'd1);
         stepCycle();
      end
      tbRty = 1'b0;
      tbErr = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      stepCycle(); settle();
      checkOutput("iso_end_grant", 32'(grant), 32'd0);

      // Watchdog: stalled slave, fires 15 cycles after the first granted strobe
      slaveStall = 1'b1;
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h80, 32'h0);
      stepCycle(); settle();
      checkOutput("wd_grant", 32'(grant), 32'd2);
      checkOutput("wd_first_s_stb", 32'(s_stb), 32'd1);
      for (int i = 1; i < 15; i++) begin
         stepCycle(); settle();
         checkOutput($sformatf("wd%0d_tmo", i), 32'(tmo), 32'd0);
         checkOutput($sformatf("wd%0d_m1_err", i), 32'(m1_err), 32'd0);
      end
      stepCycle(); settle();
      checkOutput("wd_fire_tmo", 32'(tmo), 32'd1);
      checkOutput("wd_fire_m1_err", 32'(m1_err), 32'd1);
      checkOutput("wd_fire_m0_err", 32'(m0_err), 32'd0);
      checkOutput("wd_fire_s_stb", 32'(s_stb), 32'd0);
      checkOutput("wd_fire_grant", 32'(grant), 32'd2);
      stepCycle(); settle();
      checkOutput("wd_after_tmo", 32'(tmo), 32'd0);
      checkOutput("wd_after_s_stb", 32'(s_stb), 32'd1);
      checkOutput("wd_after_m1_err", 32'(m1_err), 32'd0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      slaveStall = 1'b0;
      stepCycle(); settle();
      checkOutput("wd_end_grant", 32'(grant), 32'd0);

      // Asynchronous reset in the middle of an m1 burst
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      stepCycle(); settle();
      checkOutput("ar_grant", 32'(grant), 32'd2);
      checkOutput("ar_s_cyc", 32'(s_cyc), 32'd1);
      stepCycle(); settle();
      checkOutput("ar_m1_ack_before", 32'(m1_ack), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("ar_rst_grant", 32'(grant), 32'd0);
      checkOutput("ar_rst_s_cyc", 32'(s_cyc), 32'd0);
      checkOutput("ar_rst_s_stb", 32'(s_stb), 32'd0);
      checkOutput("ar_rst_m0_ack", 32'(m0_ack), 32'd0);
      checkOutput("ar_rst_m1_ack", 32'(m1_ack), 32'd0);
      checkOutput("ar_rst_tmo", 32'(tmo), 32'd0);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h4, 32'h0);
      #1 rst_n = 1'b1;
      stepCycle(); settle();
      checkOutput("ar_tie_grant", 32'(grant), 32'd1);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      stepCycle();

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
